// File: rtl/multi_port_memory_arbiter_pkg.sv
// Shared memory definitions for the line-memory arbiter:
// direction codes, default widths and FSM state encoding.
package multi_port_memory_arbiter_pkg;

  localparam int PHYS_ADDR_SIZE = 20;
  localparam int LINE_WIDTH     = 128;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/multi_port_memory_arbiter_grant.sv
// Combinational winner select: fixed priority (port 0 first)
// or round-robin starting one past the last winner.
module arbiter_grant #(
  parameter int N_PORTS = 2,
  parameter int RR_MODE = 0
) (
  input  logic [N_PORTS-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [2:0]         id_o,
  output logic               valid_o
);

  always_comb begin
    int p;
    id_o    = '0;
    valid_o = 1'b0;
    p       = 0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (RR_MODE != 0) begin
        p = (int'(ptr_i) + 1 + k) % N_PORTS;
      end else begin
        p = k;
      end
      if (!valid_o && req_i[p]) begin
        valid_o = 1'b1;
        id_o    = 3'(p);
      end
    end
  end

endmodule

// File: rtl/multi_port_memory_arbiter.sv
// Serialises line requests from N_PORTS cache clients onto one
// fixed-latency backing line memory.
module multi_port_memory_arbiter
  import multi_port_memory_arbiter_pkg::*;
#(
  parameter int N_PORTS     = 2,
  parameter int ADDR_W      = PHYS_ADDR_SIZE,
  parameter int LINE_W      = LINE_WIDTH,
  parameter int OFFSET_BITS = 4,
  parameter int MEM_LINES   = 4096,
  parameter int MEM_LATENCY = 5,
  parameter int RR_MODE     = 0
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         req_enable,
  input  logic [N_PORTS-1:0]         req_write_or_read,
  input  logic [N_PORTS*ADDR_W-1:0]  req_address,
  input  logic [N_PORTS*LINE_W-1:0]  req_in_data,
  output logic [LINE_W-1:0]          out_data,
  output logic [N_PORTS-1:0]         req_ready,
  output logic [2:0]                 grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         ptr_q;
  logic [2:0]         gid_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LINE_W-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic [LINE_W-1:0]  out_q;
  logic [N_PORTS-1:0] ready_q;
  logic [N_PORTS-1:0] gnt_vec;
  logic               busy_q;
  logic [2:0]         win_id;
  logic               win_vld;
  logic               commit;
  logic               unused_addr;

  logic [LINE_W-1:0] mem_q [MEM_LINES];

  arbiter_grant #(
    .N_PORTS (N_PORTS),
    .RR_MODE (RR_MODE)
  ) u_grant (
    .req_i   (req_enable),
    .ptr_i   (ptr_q),
    .id_o    (win_id),
    .valid_o (win_vld)
  );

  // Offset and upper address bits do not select a line.
  assign unused_addr = ^req_address;

  always_comb begin
    idx_d   = '0;
    data_d  = '0;
    wr_d    = READ;
    gnt_vec = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (win_id == 3'(p)) begin
        idx_d  = req_address[p*ADDR_W+OFFSET_BITS +: IDX_W];
        data_d = req_in_data[p*LINE_W +: LINE_W];
        wr_d   = req_write_or_read[p];
      end
      gnt_vec[p] = (gid_q == 3'(p));
    end
  end

  assign commit = (state_q == ST_BUSY) && (cnt_q == '0);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 3'(N_PORTS - 1);
      gid_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wr_q    <= READ;
      out_q   <= '0;
      ready_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (win_vld) begin
            gid_q   <= win_id;
            ptr_q   <= win_id;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            cnt_q   <= CNT_W'(MEM_LATENCY - 1);
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (commit) begin
            if (wr_q != WRITE) begin
              out_q <= mem_q[idx_q];
            end
            ready_q <= gnt_vec;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Backing store is deliberately outside reset.
  always_ff @(posedge clock) begin
    if (!rst && commit && wr_q == WRITE) begin
      mem_q[idx_q] <= data_q;
    end
  end

  assign out_data  = out_q;
  assign req_ready = ready_q;
  assign grant_id  = gid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multi_port_memory_arbiter.sv
// Directed bench: fixed-priority and RR two-port arbiters on
// shared stimulus plus a four-port RR instance.
module tb_multi_port_memory_arbiter;

  logic         clock = 1'b0;
  logic         rst;

  logic [1:0]   req_en;
  logic [1:0]   req_wr;
  logic [39:0]  req_addr;
  logic [255:0] req_data;

  logic [127:0] fp_out, rr_out, r4_out;
  logic [1:0]   fp_rdy, rr_rdy;
  logic [3:0]   r4_rdy;
  logic [2:0]   fp_gid, rr_gid, r4_gid;
  logic         fp_busy, rr_busy, r4_busy;

  logic [3:0]   r4_en;
  logic [3:0]   r4_wr;
  logic [79:0]  r4_addr;
  logic [511:0] r4_data;

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [127:0] L_A5   = {16{8'hA5}};
  localparam logic [127:0] L_DEAD = {8{16'hDEAD}};
  localparam logic [127:0] L_1111 = {32{4'h1}};
  localparam logic [127:0] L_2222 = {32{4'h2}};
  localparam logic [127:0] L_7777 = {32{4'h7}};

  always #5 clock = ~clock;

  multi_port_memory_arbiter #(
    .N_PORTS(2), .RR_MODE(0)
  ) u_fp (
    .clock(clock), .rst(rst),
    .req_enable(req_en), .req_write_or_read(req_wr),
    .req_address(req_addr), .req_in_data(req_data),
    .out_data(fp_out), .req_ready(fp_rdy),
    .grant_id(fp_gid), .busy(fp_busy)
  );

  multi_port_memory_arbiter #(
    .N_PORTS(2), .RR_MODE(1), .MEM_LINES(64)
  ) u_rr (
    .clock(clock), .rst(rst),
    .req_enable(req_en), .req_write_or_read(req_wr),
    .req_address(req_addr), .req_in_data(req_data),
    .out_data(rr_out), .req_ready(rr_rdy),
    .grant_id(rr_gid), .busy(rr_busy)
  );

  multi_port_memory_arbiter #(
    .N_PORTS(4), .RR_MODE(1), .MEM_LINES(64)
  ) u_r4 (
    .clock(clock), .rst(rst),
    .req_enable(r4_en), .req_write_or_read(r4_wr),
    .req_address(r4_addr), .req_in_data(r4_data),
    .out_data(r4_out), .req_ready(r4_rdy),
    .grant_id(r4_gid), .busy(r4_busy)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input int p, input logic wr,
                          input logic [19:0] a,
                          input logic [127:0] d);
    req_wr[p] = wr;
    req_addr[p*20 +: 20] = a;
    req_data[p*128 +: 128] = d;
  endtask

  task automatic do_txn(input string tag, input int p,
                        input logic wr, input logic [19:0] a,
                        input logic [127:0] d);
    int n;
    logic [1:0] want;
    set_port(p, wr, a, d);
    req_en[p] = 1'b1;
    n = 0;
    while (fp_rdy == 2'b00 && n < 20) begin
      step();
      n++;
    end
    want = 2'(1 << p);
    chk({tag, "_lat"}, 128'(n), 128'd6);
    chk({tag, "_rdy"}, 128'(fp_rdy), 128'(want));
    req_en[p] = 1'b0;
    step();
  endtask

  initial begin
    logic [1:0] fp_seq [8];
    logic [1:0] rr_seq [8];
    logic [3:0] r4_seq [8];
    logic [2:0] r4_gseq [8];
    logic [127:0] rr_p1_out;
    int fp_n, rr_n, r4_n, n;
    logic seen;

    rst = 1'b1;
    req_en = '0; req_wr = '0;
    req_addr = '0; req_data = '0;
    r4_en = '0; r4_wr = '0;
    r4_addr = '0; r4_data = '0;
    step(); step();
    chk("rst_ready", 128'(fp_rdy), 128'd0);
    chk("rst_out", fp_out, 128'd0);
    chk("rst_gid", 128'(fp_gid), 128'd0);
    chk("rst_busy", 128'(fp_busy), 128'd0);
    rst = 1'b0;
    step();

    do_txn("pre_a5", 1, 1'b1, 20'h00010, L_A5);

    // Read with exact latency tracking from grant edge G.
    set_port(0, 1'b0, 20'h00010, '0);
    req_en = 2'b01;
    step();
    chk("rd_busy_g", 128'(fp_busy), 128'd1);
    chk("rd_gid_g", 128'(fp_gid), 128'd0);
    step(); step(); step(); step();
    chk("rd_rdy_g4", 128'(fp_rdy), 128'd0);
    step();
    chk("rd_rdy_g5", 128'(fp_rdy), 128'b01);
    chk("rd_out_g5", fp_out, L_A5);
    chk("rd_busy_g5", 128'(fp_busy), 128'd1);
    req_en = 2'b00;
    step();
    chk("rd_busy_g6", 128'(fp_busy), 128'd0);
    chk("rd_rdy_g6", 128'(fp_rdy), 128'd0);
    chk("rd_hold_g6", fp_out, L_A5);

    do_txn("wr_dead", 1, 1'b1, 20'h00020, L_DEAD);
    do_txn("rd_dead", 0, 1'b0, 20'h00020, '0);
    chk("rd_dead_out", fp_out, L_DEAD);
    chk("rr_dead_out", rr_out, L_DEAD);

    do_txn("wr_7777", 0, 1'b1, 20'h00040, L_7777);
    chk("wr_keeps_out", fp_out, L_DEAD);

    do_txn("rd_upper", 0, 1'b0, 20'h10010, '0);
    chk("rd_upper_out", fp_out, L_A5);

    // Address changes after grant must be ignored.
    set_port(0, 1'b0, 20'h00010, '0);
    req_en = 2'b01;
    step();
    set_port(0, 1'b0, 20'h00020, '0);
    n = 0;
    while (fp_rdy == 2'b00 && n < 20) begin
      step();
      n++;
    end
    chk("chg_lat", 128'(n), 128'd5);
    chk("chg_out", fp_out, L_A5);
    req_en = 2'b00;
    step();

    do_txn("pre_1111", 0, 1'b1, 20'h00030, L_1111);

    // Reset two cycles into a write aborts it.
    set_port(0, 1'b1, 20'h00030, L_2222);
    req_en = 2'b01;
    step(); step(); step();
    rst = 1'b1;
    req_en = 2'b00;
    step();
    chk("abort_busy", 128'(fp_busy), 128'd0);
    chk("abort_rdy", 128'(fp_rdy), 128'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (fp_rdy != 2'b00 || fp_busy) seen = 1'b1;
    end
    chk("abort_idle", 128'(seen), 128'd0);
    do_txn("rd_abort", 0, 1'b0, 20'h00030, '0);
    chk("rd_abort_out", fp_out, L_1111);

    // Both ports hold read requests continuously.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_port(0, 1'b0, 20'h00010, '0);
    set_port(1, 1'b0, 20'h00020, '0);
    req_en = 2'b11;
    fp_n = 0; rr_n = 0;
    rr_p1_out = '0;
    for (int i = 0; i < 28; i++) begin
      step();
      if (fp_rdy != 2'b00 && fp_n < 8) begin
        fp_seq[fp_n] = fp_rdy;
        fp_n++;
      end
      if (rr_rdy != 2'b00 && rr_n < 8) begin
        rr_seq[rr_n] = rr_rdy;
        rr_n++;
        if (rr_rdy == 2'b10) rr_p1_out = rr_out;
      end
    end
    req_en = 2'b00;
    step(); step();
    chk("fp_count", 128'(fp_n), 128'd4);
    chk("rr_count", 128'(rr_n), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fp_seq%0d", i), 128'(fp_seq[i]), 128'b01);
      chk($sformatf("rr_seq%0d", i), 128'(rr_seq[i]),
          (i % 2 == 0) ? 128'b01 : 128'b10);
    end
    chk("rr_p1_out", rr_p1_out, L_DEAD);

    // Four-port RR: move ptr to 1, then ports 1 and 3 contend.
    r4_en = 4'b0010;
    n = 0;
    while (r4_rdy == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    chk("r4_first_lat", 128'(n), 128'd6);
    chk("r4_first_rdy", 128'(r4_rdy), 128'b0010);
    r4_en = 4'b0000;
    step();
    r4_en = 4'b1010;
    r4_n = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (r4_rdy != 4'b0000 && r4_n < 8) begin
        r4_seq[r4_n] = r4_rdy;
        r4_gseq[r4_n] = r4_gid;
        r4_n++;
      end
    end
    r4_en = 4'b0000;
    step();
    chk("r4_count", 128'(r4_n), 128'd2);
    chk("r4_rdy0", 128'(r4_seq[0]), 128'b1000);
    chk("r4_gid0", 128'(r4_gseq[0]), 128'd3);
    chk("r4_rdy1", 128'(r4_seq[1]), 128'b0010);
    chk("r4_gid1", 128'(r4_gseq[1]), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
